mpi_bus_responder: RTL and testbench

//  Target side of the MPI bus (nAD/nSYNC/nDIN/nDOUT/nWTBT/nRPLY). Decodes a two-word

---
 rtl/mpi_bus_responder.sv | 155 +++++++++++++++
 tb/tb_mpi_bus_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mpi_bus_responder.sv
// MPI bus target: two-word register window answering read, write-word and write-byte cycles.
// All bus lines are active-low; address/data on nADp are carried inverted.
module mpi_bus_responder #(
    parameter logic [15:0] BASE_ADDR  = 16'o177714,
    parameter int unsigned RPLY_DLY   = 1,
    parameter logic [15:0] REG1_WMASK = 16'o000377
) (
    input  logic        CLKp,
    input  logic        RSTp,
    inout  wire  [15:0] nADp,
    input  logic        nSYNCp,
    input  logic        nDINp,
    input  logic        nDOUTp,
    input  logic        nWTBTp,
    inout  wire         nRPLYp,
    input  logic [15:0] status_in,
    output logic [15:0] reg0_q,
    output logic [15:0] reg1_q,
    output logic [1:0]  wr_pulse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_MISS,
        S_DLY,
        S_REPLY,
        S_RELEASE
    } state_t;

    localparam logic [3:0]  DLY_LOAD = (RPLY_DLY == 0) ? 4'd0 : 4'(RPLY_DLY - 1);
    localparam logic [14:0] WIN_LO   = BASE_ADDR[15:1];
    localparam logic [14:0] WIN_HI   = BASE_ADDR[15:1] + 15'd1;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        sync_q;
    logic        din_q;
    logic        dout_q;
    logic [15:0] addr_q;
    logic        wr_cyc_q;
    logic [15:0] rdata_q;

    logic [15:0] bus_val;
    logic        sync_fall;
    logic        bus_hit;
    logic        sel;
    logic        enter_reply;
    logic [15:0] rd_word;
    logic [15:0] wr_base;
    logic [15:0] wr_word;
    logic        drive_rply;
    logic        drive_ad;

    assign bus_val   = ~nADp;
    assign sync_fall = sync_q & ~nSYNCp;
    assign bus_hit   = (bus_val[15:1] == WIN_LO) || (bus_val[15:1] == WIN_HI);
    assign sel       = addr_q[1] ^ BASE_ADDR[1];
    assign rd_word   = sel ? ((reg1_q & REG1_WMASK) | (status_in & ~REG1_WMASK)) : reg0_q;

    // Byte lanes follow addr[0]; the data phase nWTBTp marks a byte transfer.
    assign wr_base = sel ? reg1_q : reg0_q;
    always_comb begin
        wr_word = bus_val;
        if (!nWTBTp) begin
            wr_word = addr_q[0] ? {bus_val[15:8], wr_base[7:0]}
                                : {wr_base[15:8], bus_val[7:0]};
        end
    end

    // State register and datapath.
    always_ff @(posedge CLKp) begin
        // NOTE: non-blocking assignments only, so every register samples pre-edge values.
        if (RSTp) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sync_q   <= 1'b1;
            din_q    <= 1'b0;
            dout_q   <= 1'b0;
            addr_q   <= '0;
            wr_cyc_q <= 1'b0;
            rdata_q  <= '0;
            reg0_q   <= '0;
            reg1_q   <= '0;
            wr_pulse <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sync_q   <= nSYNCp;
            din_q    <= ~nDINp;
            dout_q   <= ~nDOUTp;
            wr_pulse <= '0;
            if (sync_fall) begin
                addr_q   <= bus_val;
                wr_cyc_q <= ~nWTBTp;
            end
            if (enter_reply) begin
                if (wr_cyc_q) begin
                    if (sel) reg1_q <= wr_word & REG1_WMASK;
                    else     reg0_q <= wr_word;
                    wr_pulse[sel] <= 1'b1;
                end else begin
                    rdata_q <= rd_word;
                end
            end
        end
    end

    // Next-state logic; strobes are registered for detection, released on the live line.
    always_comb begin
        // NOTE: defaults first so no path leaves state_d/cnt_d unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        if (nSYNCp) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sync_fall) state_d = bus_hit ? S_SEL : S_MISS;
                end
                S_SEL: begin
                    if (wr_cyc_q ? dout_q : din_q) begin
                        if (RPLY_DLY == 0) begin
                            state_d = S_REPLY;
                        end else begin
                            state_d = S_DLY;
                            cnt_d   = DLY_LOAD;
                        end
                    end
                end
                S_DLY: begin
                    if (cnt_q == 4'd0) state_d = S_REPLY;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                S_REPLY: begin
                    if (wr_cyc_q ? nDOUTp : nDINp) state_d = S_RELEASE;
                end
                S_MISS, S_RELEASE: state_d = state_q;
                default:           state_d = S_IDLE;
            endcase
        end
    end

    assign enter_reply = (state_d == S_REPLY) && (state_q != S_REPLY);

    // Bus drivers decode straight from the state register.
    always_comb begin
        drive_rply = (state_q == S_REPLY);
        drive_ad   = (state_q == S_REPLY) && !wr_cyc_q;
    end

    assign nRPLYp = drive_rply ? 1'b0 : 1'bz;
    assign nADp   = drive_ad ? ~rdata_q : 16'bz;

endmodule

// File: tb/tb_mpi_bus_responder.sv
// Directed bench for mpi_bus_responder: plays the initiator on a pulled-up MPI bus.
module tb_mpi_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        nSYNC, nDIN, nDOUT, nWTBT;
    logic        tb_oe;
    logic [15:0] tb_ad;
    logic [15:0] status;
    logic [15:0] reg0, reg1;
    logic [1:0]  wr_pulse;
    tri1  [15:0] nAD;
    tri1         nRPLY;

    int total = 0;
    int bad   = 0;

    assign nAD = tb_oe ? tb_ad : 16'bz;

    always #5 clk = ~clk;

    mpi_bus_responder dut (
        .CLKp      (clk),
        .RSTp      (rst),
        .nADp      (nAD),
        .nSYNCp    (nSYNC),
        .nDINp     (nDIN),
        .nDOUTp    (nDOUT),
        .nWTBTp    (nWTBT),
        .nRPLYp    (nRPLY),
        .status_in (status),
        .reg0_q    (reg0),
        .reg1_q    (reg1),
        .wr_pulse  (wr_pulse)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic addr_phase(input logic [15:0] addr, input logic wr);
        @(posedge clk); #1;
        tb_oe = 1'b1; tb_ad = ~addr; nWTBT = ~wr;
        @(posedge clk); #1;
        nSYNC = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic end_cycle();
        nSYNC = 1'b1; nDIN = 1'b1; nDOUT = 1'b1; nWTBT = 1'b1; tb_oe = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input string tag, input logic [15:0] addr, input logic [15:0] data,
                             input logic is_byte, input logic [1:0] exp_pulse);
        logic seen;
        addr_phase(addr, 1'b1);
        tb_ad = ~data; nWTBT = ~is_byte; nDOUT = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk); #1;
            if (nRPLY === 1'b0) seen = 1'b1;
        end
        check({tag, " reply"}, {15'd0, seen}, 16'd1);
        if (seen) begin
            check({tag, " pulse"}, {14'd0, wr_pulse}, {14'd0, exp_pulse});
            @(posedge clk); #1;
            check({tag, " pulse once"}, {14'd0, wr_pulse}, 16'd0);
            check({tag, " rply held"}, {15'd0, nRPLY}, 16'd0);
            nDOUT = 1'b1;
            @(posedge clk); #1;
            check({tag, " rply release"}, {15'd0, nRPLY}, 16'd1);
        end
        end_cycle();
    endtask

    task automatic bus_read(input string tag, input logic [15:0] addr, input logic [15:0] exp,
                            input logic chk_lat);
        logic seen;
        int   waited;
        addr_phase(addr, 1'b0);
        tb_oe = 1'b0; nDIN = 1'b0;
        seen = 1'b0; waited = 0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(posedge clk); #1;
            if (nRPLY === 1'b0) begin
                seen = 1'b1; waited = i;
            end
        end
        check({tag, " reply"}, {15'd0, seen}, 16'd1);
        if (seen) begin
            check({tag, " data"}, ~nAD, exp);
            if (chk_lat) check({tag, " latency"}, 16'(waited), 16'd3);
            nDIN = 1'b1;
            @(posedge clk); #1;
            check({tag, " rply release"}, {15'd0, nRPLY}, 16'd1);
            check({tag, " ad release"}, nAD, 16'hFFFF);
        end
        end_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic quiet;
        logic seen;
        rst = 1'b1; nSYNC = 1'b1; nDIN = 1'b1; nDOUT = 1'b1; nWTBT = 1'b1;
        tb_oe = 1'b0; tb_ad = 16'h0000; status = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check("reset reg0", reg0, 16'h0000);
        check("reset reg1", reg1, 16'h0000);
        check("reset pulse", {14'd0, wr_pulse}, 16'd0);
        check("reset rply", {15'd0, nRPLY}, 16'd1);
        check("reset ad", nAD, 16'hFFFF);
        rst = 1'b0;
        @(posedge clk); #1;

        // Byte and word writes to REG0, then read back with latency check.
        bus_write("t1 byte", 16'o177714, 16'h0055, 1'b1, 2'b01);
        check("t1 reg0", reg0, 16'h0055);
        bus_write("t2 word", 16'o177714, 16'h000F, 1'b0, 2'b01);
        check("t2 reg0", reg0, 16'h000F);
        bus_read("t2 read", 16'o177714, 16'h000F, 1'b1);

        // High-byte write at the odd address; word read at odd address returns the full word.
        bus_write("t3 byte hi", 16'o177715, 16'hAB00, 1'b1, 2'b01);
        check("t3 reg0", reg0, 16'hAB0F);
        bus_read("t3 read odd", 16'o177715, 16'hAB0F, 1'b0);

        // REG1 masking and live status bits.
        status = 16'h1200;
        bus_write("t4 reg1 word", 16'o177716, 16'hFFFF, 1'b0, 2'b10);
        check("t4 reg1", reg1, 16'h00FF);
        check("t4 reg0 kept", reg0, 16'hAB0F);
        bus_read("t4 read", 16'o177716, 16'h12FF, 1'b1);
        status = 16'h0C00;
        bus_read("t4 status live", 16'o177716, 16'h0CFF, 1'b0);

        // Write strobe on a read cycle must be ignored.
        addr_phase(16'o177714, 1'b0);
        tb_ad = ~16'h1234; nDOUT = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (nRPLY !== 1'b1 || wr_pulse !== 2'b00) quiet = 1'b0;
        end
        check("ignored dout quiet", {15'd0, quiet}, 16'd1);
        end_cycle();
        check("ignored dout reg0", reg0, 16'hAB0F);

        // Miss: read and write to 123456 never answered nor driven.
        addr_phase(16'o123456, 1'b0);
        tb_oe = 1'b0; nDIN = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (nRPLY !== 1'b1 || nAD !== 16'hFFFF) quiet = 1'b0;
        end
        check("t5 miss read quiet", {15'd0, quiet}, 16'd1);
        end_cycle();
        addr_phase(16'o123456, 1'b1);
        tb_ad = ~16'h5A5A; nDOUT = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (nRPLY !== 1'b1 || wr_pulse !== 2'b00) quiet = 1'b0;
        end
        check("t5 miss write quiet", {15'd0, quiet}, 16'd1);
        end_cycle();
        check("t5 reg0 kept", reg0, 16'hAB0F);
        check("t5 reg1 kept", reg1, 16'h00FF);
        bus_read("t5 recover", 16'o177714, 16'hAB0F, 1'b1);

        // Reset asserted while replying to a read.
        addr_phase(16'o177714, 1'b0);
        tb_oe = 1'b0; nDIN = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk); #1;
            if (nRPLY === 1'b0) seen = 1'b1;
        end
        check("t6 reply before reset", {15'd0, seen}, 16'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6 rply released", {15'd0, nRPLY}, 16'd1);
        check("t6 ad released", nAD, 16'hFFFF);
        check("t6 reg0 cleared", reg0, 16'h0000);
        check("t6 reg1 cleared", reg1, 16'h0000);
        rst = 1'b0;
        end_cycle();
        bus_write("t6 word", 16'o177714, 16'h1234, 1'b0, 2'b01);
        check("t6 reg0", reg0, 16'h1234);
        bus_read("t6 read", 16'o177714, 16'h1234, 1'b1);

        // Byte writes to REG1: high byte is fully masked, low byte lands.
        bus_write("t7 reg1 hi", 16'o177717, 16'h5500, 1'b1, 2'b10);
        check("t7 reg1 masked", reg1, 16'h0000);
        bus_write("t7 reg1 lo", 16'o177716, 16'h00A5, 1'b1, 2'b10);
        check("t7 reg1", reg1, 16'h00A5);
        bus_read("t7 read", 16'o177716, 16'h0CA5, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
